// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared Y86 encodings used by the execute-stage blocks.
//   - ifun codes for jXX / cmovXX conditions
//   - icode values of the instructions that touch the condition codes
//   - default reset value of the {ZF,SF,OF} condition-code register
// ---------------------------------------------------------------------------
package y86_pkg;

    // Condition function codes (low nibble of jXX / cmovXX)
    localparam logic [3:0] C_ALWAYS = 4'd0;
    localparam logic [3:0] C_LE     = 4'd1;
    localparam logic [3:0] C_L      = 4'd2;
    localparam logic [3:0] C_E      = 4'd3;
    localparam logic [3:0] C_NE     = 4'd4;
    localparam logic [3:0] C_GE     = 4'd5;
    localparam logic [3:0] C_G      = 4'd6;

    // Instruction codes that set or consume condition codes
    localparam logic [3:0] I_CMOVXX = 4'd2;
    localparam logic [3:0] I_OPQ    = 4'd6;
    localparam logic [3:0] I_JXX    = 4'd7;

    // {ZF,SF,OF} after reset: looks like the result of a zero-valued OPq
    localparam logic [2:0] CC_RST_DEF = 3'b100;

endpackage

// File: rtl/cc_cond_unit_cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Purely combinational Y86 condition evaluator, shared with the pipelined
// core's execute stage.
// Ports:
//   i_ifun     condition function code
//   i_zf/i_sf/i_of  condition-code flags to evaluate against
//   o_cnd      condition result (0 for any unknown code)
//   o_illegal  high when i_ifun is not a defined condition (> 6)
// ---------------------------------------------------------------------------
module cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] i_ifun,
    input  logic       i_zf,
    input  logic       i_sf,
    input  logic       i_of,
    output logic       o_cnd,
    output logic       o_illegal
);

    logic w_less;

    // Signed "less than" of the last OPq is the sign corrected by overflow
    assign w_less = i_sf ^ i_of;

    always_comb begin
        o_cnd     = 1'b0;
        o_illegal = 1'b0;
        case (i_ifun)
            C_ALWAYS: o_cnd = 1'b1;
            C_LE:     o_cnd = w_less | i_zf;
            C_L:      o_cnd = w_less;
            C_E:      o_cnd = i_zf;
            C_NE:     o_cnd = ~i_zf;
            C_GE:     o_cnd = ~w_less;
            C_G:      o_cnd = ~w_less & ~i_zf;
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cc_cond_unit.sv
// ---------------------------------------------------------------------------
// cc_cond_unit
// Condition-code register plus registered condition-query port, sitting
// after the 64-bit ALU in the execute stage.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   set_valid             alu_out/alu_of hold an OPq result to latch
//   alu_out, alu_of       ALU result and signed-overflow flag
//   set_block             later stage holds an exception; no CC update
//   stall                 freeze all state and registered outputs
//   q_valid, q_ifun       condition query and its ifun code
//   zf, sf, of            current condition codes
//   cnd_valid, cnd        registered query result (1-cycle latency)
//   cnd_illegal           registered; query used an undefined ifun
// ---------------------------------------------------------------------------
module cc_cond_unit
    import y86_pkg::*;
#(
    parameter int         W      = 64,
    parameter logic [2:0] CC_RST = CC_RST_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         set_valid,
    input  logic [W-1:0] alu_out,
    input  logic         alu_of,
    input  logic         set_block,
    input  logic         stall,
    input  logic         q_valid,
    input  logic [3:0]   q_ifun,
    output logic         zf,
    output logic         sf,
    output logic         of,
    output logic         cnd_valid,
    output logic         cnd,
    output logic         cnd_illegal
);

    logic r_zf;
    logic r_sf;
    logic r_of;
    logic r_cndValid;
    logic r_cnd;
    logic r_cndIllegal;
    logic w_cnd;
    logic w_illegal;
    logic w_ccWrite;

    // The query is evaluated on the flags currently held, so a query in
    // the same cycle as an update still sees the previous OPq's flags.
    cond_eval u_cond_eval (
        .i_ifun    (q_ifun),
        .i_zf      (r_zf),
        .i_sf      (r_sf),
        .i_of      (r_of),
        .o_cnd     (w_cnd),
        .o_illegal (w_illegal)
    );

    assign w_ccWrite = set_valid & ~set_block & ~stall;

    // Flag register: only a live, non-squashed OPq moves the flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r_zf, r_sf, r_of} <= CC_RST;
        end else if (w_ccWrite) begin
            r_zf <= (alu_out == '0);
            r_sf <= alu_out[W-1];
            r_of <= alu_of;
        end
    end

    // Query register: an idle cycle clears the result, a stall holds it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cndValid   <= 1'b0;
            r_cnd        <= 1'b0;
            r_cndIllegal <= 1'b0;
        end else if (!stall) begin
            r_cndValid   <= q_valid;
            r_cnd        <= q_valid & w_cnd;
            r_cndIllegal <= q_valid & w_illegal;
        end
    end

    assign zf          = r_zf;
    assign sf          = r_sf;
    assign of          = r_of;
    assign cnd_valid   = r_cndValid;
    assign cnd         = r_cnd;
    assign cnd_illegal = r_cndIllegal;

endmodule

// File: tb/tb_cc_cond_unit.sv
// ---------------------------------------------------------------------------
// tb_cc_cond_unit
// Scoreboard bench: the driver pushes the expected post-edge outputs into a
// queue, and a monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_cc_cond_unit;

    localparam int W = 64;

    logic         clk;
    logic         rst;
    logic         set_valid;
    logic [W-1:0] alu_out;
    logic         alu_of;
    logic         set_block;
    logic         stall;
    logic         q_valid;
    logic [3:0]   q_ifun;
    logic         zf;
    logic         sf;
    logic         of;
    logic         cnd_valid;
    logic         cnd;
    logic         cnd_illegal;

    // {zf, sf, of, cnd_valid, cnd, cnd_illegal}
    typedef logic [5:0] exp_t;

    exp_t expQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   cycleNo     = 0;

    // Reference state: what the flags mean and what the last answer was
    bit mZero;
    bit mNeg;
    bit mOvf;
    bit mValid;
    bit mCnd;
    bit mIllegal;

    cc_cond_unit #(.W(W), .CC_RST(3'b100)) dut (
        .clk         (clk),
        .rst         (rst),
        .set_valid   (set_valid),
        .alu_out     (alu_out),
        .alu_of      (alu_of),
        .set_block   (set_block),
        .stall       (stall),
        .q_valid     (q_valid),
        .q_ifun      (q_ifun),
        .zf          (zf),
        .sf          (sf),
        .of          (of),
        .cnd_valid   (cnd_valid),
        .cnd         (cnd),
        .cnd_illegal (cnd_illegal)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the driver ever stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Condition meaning in terms of "signed less" and "equal"
    function automatic bit modelCond(input int f, input bit z, input bit s, input bit o);
        bit less;
        less = (s != o);
        case (f)
            0:       return 1'b1;
            1:       return less || z;
            2:       return less;
            3:       return z;
            4:       return !z;
            5:       return !less;
            6:       return !less && !z;
            default: return 1'b0;
        endcase
    endfunction

    task automatic modelReset();
        mZero    = 1'b1;
        mNeg     = 1'b0;
        mOvf     = 1'b0;
        mValid   = 1'b0;
        mCnd     = 1'b0;
        mIllegal = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model, queue the expectation
    task automatic applyStimulus(input bit sv, input logic [W-1:0] res, input bit aof,
                                 input bit blk, input bit stl, input bit qv, input int f);
        @(negedge clk);
        #1;
        set_valid = sv;
        alu_out   = res;
        alu_of    = aof;
        set_block = blk;
        stall     = stl;
        q_valid   = qv;
        q_ifun    = 4'(f);
        if (!stl) begin
            mValid   = qv;
            mCnd     = qv && modelCond(f, mZero, mNeg, mOvf);
            mIllegal = qv && (f > 6);
            if (sv && !blk) begin
                mZero = (res == 0);
                mNeg  = res[W-1];
                mOvf  = aof;
            end
        end
        expQ.push_back({mZero, mNeg, mOvf, mValid, mCnd, mIllegal});
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic setCc(input logic [W-1:0] res, input bit aof);
        applyStimulus(1'b1, res, aof, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic query(input int f);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, f);
    endtask

    task automatic checkOutput(input string name, input exp_t got, input exp_t want);
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL %s: got {zf,sf,of,vld,cnd,ill}=%b expected %b", name, got, want);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare away from posedge
    always @(negedge clk) begin
        cycleNo++;
        if (expQ.size() != 0) begin
            exp_t want;
            want = expQ.pop_front();
            checkOutput($sformatf("cycle%0d", cycleNo),
                        {zf, sf, of, cnd_valid, cnd, cnd_illegal}, want);
        end
    end

    initial begin
        logic [W-1:0] r;
        set_valid = 1'b0;
        alu_out   = '0;
        alu_of    = 1'b0;
        set_block = 1'b0;
        stall     = 1'b0;
        q_valid   = 1'b0;
        q_ifun    = 4'd0;
        rst       = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        checkOutput("reset_state", {zf, sf, of, cnd_valid, cnd, cnd_illegal}, 6'b100000);

        // Asynchronous reset in the middle of a cycle with a live result
        query(0);
        @(negedge clk);
        #3;
        q_valid = 1'b0;
        checkOutput("pre_reset_valid", {5'b0, cnd_valid}, 6'b000001);
        rst = 1'b1;
        #1;
        checkOutput("async_reset", {zf, sf, of, cnd_valid, cnd, cnd_illegal}, 6'b100000);
        rst = 1'b0;
        modelReset();
        query(3);
        idle();

        // Positive result 256-255
        setCc(64'd256 - 64'd255, 1'b0);
        query(6);
        query(1);

        // Signed overflow into the sign bit
        setCc(64'h8000_0000_0000_0000, 1'b1);
        query(2);
        query(5);

        // Same-cycle update and query: query sees the older zf=1 flags
        setCc(64'd0, 1'b0);
        applyStimulus(1'b1, 64'(-64'sd543 - -64'sd464), 1'b0, 1'b0, 1'b0, 1'b1, 3);
        query(3);
        query(2);

        // Gating: blocked update, then a stalled update+query
        applyStimulus(1'b1, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        query(0);
        applyStimulus(1'b1, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4);
        applyStimulus(1'b1, 64'd0, 1'b1, 1'b1, 1'b1, 1'b1, 9);

        // Undefined condition code, then an idle cycle clears it
        query(9);
        idle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       r = '0;
                1:       r = {$urandom(), $urandom()} | 64'h8000_0000_0000_0000;
                default: r = {$urandom(), $urandom()};
            endcase
            applyStimulus(1'($urandom_range(0, 1)), r, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        end
        idle();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
